// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiply / restoring divide unit that owns the Hi/Lo result registers.
// Optional MULDIV_SIGNED_EN selects two's-complement (MIPS mult/div) semantics; otherwise unsigned only.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum, shifted, diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rmd;

  always_comb begin
`ifdef MULDIV_SIGNED_EN
    sign_a = op_a[WIDTH-1];
    sign_b = op_b[WIDTH-1];
    mag_a  = sign_a ? -op_a : op_a;
    mag_b  = sign_b ? -op_b : op_b;
`else
    sign_a = 1'b0;
    sign_b = 1'b0;
    mag_a  = op_a;
    mag_b  = op_b;
`endif
    // Multiply: acc = {partial product, remaining multiplier bits}.
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // Divide: acc low half shifts the dividend out MSB-first and the quotient in.
    shifted = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_q};
    prod    = neg_res_q ? -acc_q : acc_q;
    quo     = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rmd     = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    state_d   = state_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start_mult || start_div) begin
          cnt_d     = '0;
          busy_d    = 1'b1;
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          rem_d     = '0;
          if (start_mult) begin
            state_d  = S_MULT;
            is_div_d = 1'b0;
            opnd_d   = mag_a;
            acc_d    = {{WIDTH{1'b0}}, mag_b};
          end else if (op_b == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            dz_d    = 1'b1;
          end else begin
            state_d  = S_DIV;
            is_div_d = 1'b1;
            opnd_d   = mag_b;
            acc_d    = {{WIDTH{1'b0}}, mag_a};
          end
        end
      end
      S_MULT: begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_DIV: begin
        if (!diff[WIDTH]) begin
          rem_d = diff;
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted;
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rmd;
          lo_d = quo;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against a plain-arithmetic reference model.
// Honors MULDIV_SIGNED_EN the same way as the design build.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_mult, start_div;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] m_hi, m_lo;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected result of one operation from plain arithmetic.
  task automatic model(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] eh, output logic [W-1:0] el, output bit dz);
    logic [63:0] r, q;
`ifdef MULDIV_SIGNED_EN
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
`else
    logic [63:0] sa, sb;
    sa = {32'b0, a};
    sb = {32'b0, b};
`endif
    dz = 1'b0;
    eh = m_hi;
    el = m_lo;
    if (!is_div) begin
      r  = sa * sb;
      eh = r[63:32];
      el = r[31:0];
    end else if (b == '0) begin
      dz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      eh = r[31:0];
      el = q[31:0];
    end
  endtask

  task automatic run_op(input bit mul, input bit dv, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int inject);
    logic [W-1:0] eh, el;
    bit dz;
    int n, busy_err, hold_err;
    model(!mul, a, b, eh, el, dz);
    @(posedge clk); #1;
    start_mult = mul; start_div = dv; op_a = a; op_b = b;
    @(posedge clk); #1;
    start_mult = 0; start_div = 0; op_a = $urandom; op_b = $urandom;
    if (dz) begin
      check("dz_done", done, 1);
      check("dz_flag", div_zero, 1);
      check("dz_hi", hi, m_hi);
      check("dz_lo", lo, m_lo);
    end else begin
      n = 0; busy_err = 0; hold_err = 0;
      while (!done && n < 60) begin
        if (!busy) busy_err++;
        if (hi !== m_hi || lo !== m_lo) hold_err++;
        if (n == inject) begin
          start_mult = 1; start_div = 1; op_a = $urandom; op_b = $urandom;
        end
        @(posedge clk); #1;
        start_mult = 0; start_div = 0;
        n++;
      end
      check("latency", n, W + 1);
      check("busy_run", busy_err, 0);
      check("hold_mid", hold_err, 0);
      check("busy_done", busy, 1);
      check("dz_low", div_zero, 0);
      check("hi", hi, eh);
      check("lo", lo, el);
      m_hi = eh;
      m_lo = el;
    end
    @(posedge clk); #1;
    check("done_clr", done, 0);
    check("busy_clr", busy, 0);
    check("dz_clr", div_zero, 0);
  endtask

  task automatic reset_mid_op();
    int dones;
    @(posedge clk); #1;
    start_mult = 1; op_a = 32'h1234_5678; op_b = 32'h9abc_def1;
    @(posedge clk); #1;
    start_mult = 0;
    repeat (9) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("rst_busy", busy, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    m_hi = '0;
    m_lo = '0;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("rst_no_done", dones, 0);
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = $urandom_range(0, 20);
      2: v = -$urandom_range(1, 20);
      default: v = {$urandom_range(0, 1) == 1, 31'($urandom_range(0, 3))};
    endcase
    return v;
  endfunction

  initial begin
    reset = 1; start_mult = 0; start_div = 0; op_a = '0; op_b = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    check("rst_busy0", busy, 0);
    check("rst_done0", done, 0);
    check("rst_dz0", div_zero, 0);
    check("rst_hi0", hi, 0);
    check("rst_lo0", lo, 0);

    run_op(1, 0, 32'd7, 32'hFFFF_FFFD, -1);
    run_op(0, 1, 32'd100, 32'd7, -1);
    run_op(0, 1, 32'd55, 32'd0, -1);
    run_op(0, 1, 32'hFFFF_FFF9, 32'd2, -1);
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op(1, 0, $urandom, $urandom, 4);
    run_op(1, 1, 32'd6, 32'd3, -1);
    reset_mid_op();

    for (int i = 0; i < 40; i++) begin
      int kind;
      logic [W-1:0] a, b;
      kind = $urandom_range(0, 3);
      a = rand_op();
      b = rand_op();
      if (kind == 3 && $urandom_range(0, 1) == 1) b = '0;
      run_op(kind == 0 || kind == 2, kind != 0, a, b,
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
